// File: rtl/biquad_coeff_pkg.sv
// Shared types and constants for the biquad coefficient controller.
package biquad_coeff_pkg;

  localparam int COEFF_W = 18;

  localparam logic [4:0] REG_CTRL       = 5'd0;
  localparam logic [4:0] REG_COEFF_BASE = 5'd16;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_PENDING = 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    UPDATE
  } state_t;

  function automatic logic [31:0] status_word(input int ncoeff, input int nchan,
                                              input logic pending, input logic busy);
    logic [31:0] w;
    w = '0;
    w[23:16] = ncoeff[7:0];
    w[15:8]  = nchan[7:0];
    w[STAT_PENDING] = pending;
    w[STAT_BUSY]    = busy;
    return w;
  endfunction

endpackage

// File: rtl/biquad_coeff_ctrl_if.sv
// WISHBONE slave bus bundle for the biquad coefficient controller.
interface biquad_coeff_ctrl_if #(
  parameter int ADR_W = 11
);
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_we_i;
  logic [ADR_W-1:0] wb_adr_i;
  logic [3:0]       wb_sel_i;
  logic [31:0]      wb_dat_i;
  logic             wb_ack_o;
  logic             wb_err_o;
  logic             wb_rty_o;
  logic [31:0]      wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/biquad_coeff_shadow.sv
// Per-channel shadow coefficient RAM: byte-enable write port, async stream and readback ports.
module biquad_coeff_shadow
  import biquad_coeff_pkg::*;
#(
  parameter int NCHAN     = 4,
  parameter int CHAN_BITS = 4,
  parameter int NCOEFF    = 12
) (
  input  logic                 clk_i,
  input  logic [NCHAN-1:0]     wr_mask_i,
  input  logic [3:0]           wr_idx_i,
  input  logic [2:0]           wr_sel_i,
  input  logic [COEFF_W-1:0]   wr_dat_i,
  input  logic [CHAN_BITS-1:0] st_chan_i,
  input  logic [3:0]           st_idx_i,
  output logic [COEFF_W-1:0]   st_dat_o,
  input  logic [CHAN_BITS-1:0] rb_chan_i,
  input  logic [3:0]           rb_idx_i,
  output logic [COEFF_W-1:0]   rb_dat_o
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;

  logic [COEFF_W-1:0] mem [NCHAN][NCOEFF];

  // Deliberately unreset so coefficients survive a controller reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (wr_mask_i[c] && (int'(wr_idx_i) < NCOEFF)) begin
        if (wr_sel_i[0]) mem[c][wr_idx_i[IW-1:0]][7:0]   <= wr_dat_i[7:0];
        if (wr_sel_i[1]) mem[c][wr_idx_i[IW-1:0]][15:8]  <= wr_dat_i[15:8];
        if (wr_sel_i[2]) mem[c][wr_idx_i[IW-1:0]][17:16] <= wr_dat_i[17:16];
      end
    end
  end

  assign st_dat_o = ((int'(st_chan_i) < NCHAN) && (int'(st_idx_i) < NCOEFF)) ?
                    mem[st_chan_i[CW-1:0]][st_idx_i[IW-1:0]] : '0;
  assign rb_dat_o = ((int'(rb_chan_i) < NCHAN) && (int'(rb_idx_i) < NCOEFF)) ?
                    mem[rb_chan_i[CW-1:0]][rb_idx_i[IW-1:0]] : '0;

endmodule

// File: rtl/biquad_coeff_ctrl.sv
// WISHBONE coefficient controller: shadows biquad coefficients and streams a channel on commit.
// Optional broadcast channel (all-ones channel field) is enabled by defining BIQUAD_COEFF_BCAST_EN.
module biquad_coeff_ctrl
  import biquad_coeff_pkg::*;
#(
  parameter int NCHAN     = 4,
  parameter int CHAN_BITS = 4,
  parameter int NCOEFF    = 12,
  parameter int ADR_W     = CHAN_BITS + 7
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  biquad_coeff_ctrl_if.slave wb,
  input  logic               global_update_i,
  output logic [COEFF_W-1:0] coeff_dat_o,
  output logic [3:0]         coeff_idx_o,
  output logic [NCHAN-1:0]   coeff_wr_o,
  output logic [NCHAN-1:0]   update_o,
  output logic               busy_o
);

  logic [CHAN_BITS-1:0] req_chan, rd_chan;
  logic [4:0]           req_reg;
  logic [3:0]           req_idx;
  logic                 is_bcast, chan_ok, is_ctrl, is_coeff;
  logic [NCHAN-1:0]     chan_mask;
  logic                 busy_int, wb_req, stall, commit, coeff_wr_en;
  logic [31:0]          rdata;
  logic [COEFF_W-1:0]   st_dat, rb_dat;
  logic                 unused_bits;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [CHAN_BITS-1:0] ch_q, ch_d;
  logic [NCHAN-1:0]     mask_q, mask_d;
  logic                 pending_q, pending_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [NCHAN-1:0]     coeff_wr_q, coeff_wr_d;
  logic [3:0]           coeff_idx_q, coeff_idx_d;
  logic [COEFF_W-1:0]   coeff_dat_q, coeff_dat_d;
  logic [NCHAN-1:0]     update_q, update_d;

  assign req_chan = wb.wb_adr_i[ADR_W-1:7];
  assign req_reg  = wb.wb_adr_i[6:2];
  assign req_idx  = req_reg[3:0];
  assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_sel_i[3], wb.wb_dat_i[31:18]};

`ifdef BIQUAD_COEFF_BCAST_EN
  localparam logic [CHAN_BITS-1:0] BCAST_CHAN = '1;
  assign is_bcast = (req_chan == BCAST_CHAN);
`else
  assign is_bcast = 1'b0;
`endif

  assign chan_ok  = (int'(req_chan) < NCHAN) || is_bcast;
  assign is_ctrl  = (req_reg == REG_CTRL);
  assign is_coeff = (req_reg >= REG_COEFF_BASE) && (int'(req_idx) < NCOEFF);
  assign rd_chan  = is_bcast ? '0 : req_chan;

  always_comb begin
    chan_mask = '0;
    for (int c = 0; c < NCHAN; c++) begin
      chan_mask[c] = is_bcast || (req_chan == CHAN_BITS'(c));
    end
  end

  // Mapped control/coeff writes wait out a stream so the streamed data stays coherent.
  assign busy_int    = busy_q || (state_q != IDLE);
  assign wb_req      = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
  assign stall       = wb.wb_we_i && chan_ok && (is_ctrl || is_coeff) && busy_int;
  assign ack_d       = wb_req && !stall;
  assign commit      = ack_d && wb.wb_we_i && chan_ok && is_ctrl && wb.wb_dat_i[0];
  assign coeff_wr_en = ack_d && wb.wb_we_i && chan_ok && is_coeff;

  biquad_coeff_shadow #(
    .NCHAN    (NCHAN),
    .CHAN_BITS(CHAN_BITS),
    .NCOEFF   (NCOEFF)
  ) u_shadow (
    .clk_i    (wb_clk_i),
    .wr_mask_i(coeff_wr_en ? chan_mask : '0),
    .wr_idx_i (req_idx),
    .wr_sel_i (wb.wb_sel_i[2:0]),
    .wr_dat_i (wb.wb_dat_i[COEFF_W-1:0]),
    .st_chan_i(ch_q),
    .st_idx_i (idx_q),
    .st_dat_o (st_dat),
    .rb_chan_i(rd_chan),
    .rb_idx_i (req_idx),
    .rb_dat_o (rb_dat)
  );

  always_comb begin
    rdata = '0;
    if (chan_ok) begin
      if (is_ctrl)       rdata = status_word(NCOEFF, NCHAN, pending_q, busy_q);
      else if (is_coeff) rdata = 32'(rb_dat);
    end
    dat_d = (ack_d && !wb.wb_we_i) ? rdata : '0;
  end

  // Outputs are registered from the state, so they trail the FSM by one clock.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    pending_d   = pending_q;
    busy_d      = (state_q != IDLE);
    coeff_wr_d  = '0;
    coeff_idx_d = '0;
    coeff_dat_d = '0;
    update_d    = '0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d   = STREAM;
          idx_d     = '0;
          ch_d      = rd_chan;
          mask_d    = chan_mask;
          pending_d = global_update_i;
        end else if (global_update_i) begin
          update_d = '1;
        end
      end
      STREAM: begin
        coeff_wr_d  = mask_q;
        coeff_idx_d = idx_q;
        coeff_dat_d = st_dat;
        if (global_update_i) pending_d = 1'b1;
        if (idx_q == 4'(NCOEFF - 1)) state_d = UPDATE;
        else                         idx_d   = idx_q + 4'd1;
      end
      UPDATE: begin
        update_d  = (pending_q || global_update_i) ? '1 : mask_q;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ch_q        <= '0;
      mask_q      <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      coeff_wr_q  <= '0;
      coeff_idx_q <= '0;
      coeff_dat_q <= '0;
      update_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      coeff_wr_q  <= coeff_wr_d;
      coeff_idx_q <= coeff_idx_d;
      coeff_dat_q <= coeff_dat_d;
      update_q    <= update_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign coeff_wr_o  = coeff_wr_q;
  assign coeff_idx_o = coeff_idx_q;
  assign coeff_dat_o = coeff_dat_q;
  assign update_o    = update_q;
  assign busy_o      = busy_q;

endmodule
